// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, one result bit per clock, LSB first.
// Define SERIAL_SUB_BORROW_IN_EN to add a borrow_in port that seeds the initial borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
    input  logic             borrow_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);

    // state | meaning
    // IDLE  | waiting for start; last result held on outputs
    // SHIFT | one full-subtract step per cycle, WIDTH cycles
    // DONE  | result valid, done pulses; start here chains a new op

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter sized to hold WIDTH so the final increment never wraps.
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic [CW-1:0]    count;

    logic             accept;
    logic             last_step;
    logic             borrow_init;
    logic             step_bit;
    logic             step_borrow;

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign borrow_init = borrow_in;
`else
    assign borrow_init = 1'b0;
`endif

    assign accept    = start && (state != SHIFT);
    assign last_step = (state == SHIFT) && (count == LAST);

    assign step_bit    = a_reg[0] ^ b_reg[0] ^ borrow_reg;
    assign step_borrow = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath holds its contents outside SHIFT so the result survives DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            count      <= '0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            diff_reg   <= '0;
            borrow_reg <= borrow_init;
            count      <= '0;
        end else if (state == SHIFT) begin
            a_reg      <= a_reg >> 1;
            b_reg      <= b_reg >> 1;
            diff_reg   <= {step_bit, diff_reg[WIDTH-1:1]};
            borrow_reg <= step_borrow;
            count      <= count + CW'(1);
        end
    end

    assign difference = diff_reg;
    assign borrow     = borrow_reg;

endmodule
